stream_rd_gen: RTL and testbench

- Command-driven read sequencer that sits directly upstream of the packing FIFO stage.
- Accepts a unit-addressed, unit-length read command and issues word reads to a memory port with fixed request/response semantics.
- Buffers the returned words and emits one annotated beat per word: valid-unit count, offset, begin/done/last flags, carried destination offset and user info. This is exactly the src-side field set the packing stage consumes.
- Credit-limited outstanding reads, so the response port never needs backpressure.

---
 rtl/stream_rd_gen.sv | 170 +++++++++++++++++
 tb/tb_stream_rd_gen.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rd_gen.sv
// stream_rd_gen: command-driven word read sequencer that emits unit-annotated beats for the packing stage.
module stream_rd_gen #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_UNIT       = 8,
    parameter int USER_INFO_WIDTH = 8,
    parameter int ADDR_WIDTH      = 32,
    parameter int LEN_WIDTH       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     flush,
    input  logic                                     cmd_valid,
    output logic                                     cmd_ready,
    input  logic [ADDR_WIDTH-1:0]                    cmd_addr,
    input  logic [LEN_WIDTH-1:0]                     cmd_len,
    input  logic [$clog2(DATA_WIDTH/DATA_UNIT)-1:0]  cmd_dst_offset,
    input  logic                                     cmd_last,
    input  logic [USER_INFO_WIDTH-1:0]               cmd_user_info,
    output logic                                     rd_req_valid,
    input  logic                                     rd_req_ready,
    output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/DATA_UNIT)-1:0] rd_req_addr,
    input  logic                                     rd_rsp_valid,
    input  logic [DATA_WIDTH-1:0]                    rd_rsp_data,
    output logic                                     dst_valid,
    input  logic                                     dst_ready,
    output logic [DATA_WIDTH-1:0]                    dst_data,
    output logic                                     dst_bgin,
    output logic [$clog2(DATA_WIDTH/DATA_UNIT):0]    dst_unit_num,
    output logic                                     dst_done,
    output logic                                     dst_last,
    output logic [$clog2(DATA_WIDTH/DATA_UNIT)-1:0]  dst_offset,
    output logic [$clog2(DATA_WIDTH/DATA_UNIT)-1:0]  dst_initial_offset,
    output logic [USER_INFO_WIDTH-1:0]               dst_user_info
);
    localparam int N  = DATA_WIDTH / DATA_UNIT;
    localparam int OW = $clog2(N);
    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam int CW = AW + 1;
    localparam int WW = ADDR_WIDTH - OW;
    localparam logic [OW:0] N_UNITS = (OW+1)'(N);

    typedef enum logic {IDLE, ISSUE} state_t;
    typedef struct packed {
        logic                       bgin;
        logic [OW:0]                unit_num;
        logic [OW-1:0]              offset;
        logic                       done;
        logic                       last;
        logic [OW-1:0]              init_off;
        logic [USER_INFO_WIDTH-1:0] user;
    } meta_t;

    state_t state, state_nxt;
    logic [WW-1:0] word_addr;
    logic first, c_last;
    logic [OW-1:0] off, c_init;
    logic [LEN_WIDTH-1:0] remaining;
    logic [USER_INFO_WIDTH-1:0] c_user;
    logic [CW-1:0] credits, inflight, discard_cnt, d_cnt;
    logic [AW-1:0] d_wp, d_rp, m_wp, m_rp;
    logic [DATA_WIDTH-1:0] dmem [MAX_OUTSTANDING];
    meta_t mmem [MAX_OUTSTANDING];
    meta_t meta_in, mh;
    logic [OW:0] avail, beat_units;
    logic beat_done, cmd_hs, req_hs, dst_hs, rsp_push;

    assign cmd_hs     = cmd_valid & cmd_ready;
    assign req_hs     = rd_req_valid & rd_req_ready;
    assign dst_hs     = dst_valid & dst_ready;
    assign rsp_push   = rd_rsp_valid && discard_cnt == '0;
    assign avail      = N_UNITS - (first ? {1'b0, off} : '0);
    assign beat_done  = remaining <= LEN_WIDTH'(avail);
    assign beat_units = beat_done ? remaining[OW:0] : avail;
    assign meta_in    = '{bgin: first, unit_num: beat_units, offset: first ? off : '0, done: beat_done,
                          last: c_last & beat_done, init_off: c_init, user: c_user};
    assign rd_req_addr = word_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = flush ? IDLE :
                    state == IDLE ? ((cmd_hs && cmd_len != '0) ? ISSUE : IDLE) :
                    (req_hs && beat_done) ? IDLE : ISSUE;
    end

    always_comb begin
        cmd_ready    = state == IDLE && discard_cnt == '0;
        rd_req_valid = state == ISSUE && credits < CW'(MAX_OUTSTANDING);
    end

    // Credits bound data-FIFO occupancy, so responses are always pushed without backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_addr   <= '0;
            first       <= 1'b0;
            off         <= '0;
            remaining   <= '0;
            c_last      <= 1'b0;
            c_init      <= '0;
            c_user      <= '0;
            credits     <= '0;
            inflight    <= '0;
            discard_cnt <= '0;
            d_cnt       <= '0;
            d_wp        <= '0;
            d_rp        <= '0;
            m_wp        <= '0;
            m_rp        <= '0;
        end else begin
            inflight <= inflight + CW'(req_hs) - CW'(rd_rsp_valid);
            if (flush) begin
                credits     <= '0;
                discard_cnt <= inflight + CW'(req_hs) - CW'(rd_rsp_valid);
                d_cnt       <= '0;
                d_wp        <= '0;
                d_rp        <= '0;
                m_wp        <= '0;
                m_rp        <= '0;
            end else begin
                if (cmd_hs) begin
                    word_addr <= cmd_addr[ADDR_WIDTH-1:OW];
                    first     <= 1'b1;
                    off       <= cmd_addr[OW-1:0];
                    remaining <= cmd_len;
                    c_last    <= cmd_last;
                    c_init    <= cmd_dst_offset;
                    c_user    <= cmd_user_info;
                end
                if (req_hs) begin
                    remaining <= remaining - LEN_WIDTH'(beat_units);
                    word_addr <= word_addr + WW'(1);
                    first     <= 1'b0;
                    m_wp      <= m_wp + AW'(1);
                end
                if (rsp_push) d_wp <= d_wp + AW'(1);
                if (dst_hs) begin
                    d_rp <= d_rp + AW'(1);
                    m_rp <= m_rp + AW'(1);
                end
                credits <= credits + CW'(req_hs) - CW'(dst_hs);
                d_cnt   <= d_cnt + CW'(rsp_push) - CW'(dst_hs);
                if (discard_cnt != '0 && rd_rsp_valid) discard_cnt <= discard_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_push) dmem[d_wp] <= rd_rsp_data;
        if (req_hs)   mmem[m_wp] <= meta_in;
    end

    always_comb begin
        dst_valid          = d_cnt != '0;
        mh                 = dst_valid ? mmem[m_rp] : '0;
        dst_data           = dst_valid ? dmem[d_rp] : '0;
        dst_bgin           = mh.bgin;
        dst_unit_num       = mh.unit_num;
        dst_done           = mh.done;
        dst_last           = mh.last;
        dst_offset         = mh.offset;
        dst_initial_offset = mh.init_off;
        dst_user_info      = mh.user;
    end

    rsp_without_request: assert property (@(posedge clk) disable iff (!rst_n) !(rd_rsp_valid && inflight == '0));
endmodule

// File: tb/tb_stream_rd_gen.sv
// tb_stream_rd_gen: directed table, hand-written corner sequences and randomized commands against a unit-level model.
module tb_stream_rd_gen;
    localparam int N  = 4;
    localparam int MO = 4;

    logic clk = 0, rst_n = 0, flush = 0, cmd_valid = 0, cmd_ready;
    logic [31:0] cmd_addr = 0;
    logic [15:0] cmd_len = 0;
    logic [1:0]  cmd_dst_offset = 0;
    logic        cmd_last = 0;
    logic [7:0]  cmd_user_info = 0;
    logic        rd_req_valid, rd_req_ready = 0;
    logic [29:0] rd_req_addr;
    logic        rd_rsp_valid = 0;
    logic [31:0] rd_rsp_data = 0;
    logic        dst_valid, dst_ready = 0;
    logic [31:0] dst_data;
    logic        dst_bgin, dst_done, dst_last;
    logic [2:0]  dst_unit_num;
    logic [1:0]  dst_offset, dst_initial_offset;
    logic [7:0]  dst_user_info;

    stream_rd_gen dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_dst_offset(cmd_dst_offset), .cmd_last(cmd_last), .cmd_user_info(cmd_user_info),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data), .dst_bgin(dst_bgin),
        .dst_unit_num(dst_unit_num), .dst_done(dst_done), .dst_last(dst_last), .dst_offset(dst_offset),
        .dst_initial_offset(dst_initial_offset), .dst_user_info(dst_user_info)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        bgin;
        logic [2:0]  unit;
        logic        done;
        logic        last;
        logic [1:0]  off;
        logic [1:0]  init;
        logic [7:0]  user;
    } beat_t;
    typedef struct { logic [29:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] addr; int len; int beats; int fu; int fo; int lu; } vec_t;

    beat_t exp_q[$];
    logic [29:0] req_q[$];
    pend_t pend[$];
    int tests = 0, fails = 0, cyc = 0, lat = 2, req_pct = 100, dst_mode = 1, rsp_budget = -1, last_due = 0;
    int outstanding = 0, req_cnt = 0, beat_cnt = 0, done_cnt = 0, last_cnt = 0;
    int obs_n, obs_fu, obs_fo, obs_lu;
    bit acc, prev_stall;
    beat_t prev_b;

    function automatic logic [31:0] mem_word(logic [29:0] a);
        return ({2'b0, a} * 32'h9E3779B1) ^ 32'h00C0FFEE;
    endfunction

    function automatic beat_t obs_beat();
        return {dst_data, dst_bgin, dst_unit_num, dst_done, dst_last, dst_offset, dst_initial_offset, dst_user_info};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(string nm, logic [63:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got %0h with nothing expected (cycle %0d)", nm, act, cyc);
    endtask

    // Reference: walk the command unit by unit, cutting a beat at every word boundary.
    task automatic model_cmd(logic [31:0] a, int len, logic [1:0] doff, logic lst, logic [7:0] u);
        logic [31:0] pos;
        int rem, o, un;
        bit fst;
        beat_t b;
        pos = a;
        rem = len;
        fst = 1;
        while (rem > 0) begin
            o  = int'(pos % N);
            un = (N - o < rem) ? N - o : rem;
            b.data = mem_word(pos[31:2]);
            b.bgin = fst;
            b.unit = 3'(un);
            b.done = (un == rem);
            b.last = lst && (un == rem);
            b.off  = 2'(o);
            b.init = doff;
            b.user = u;
            exp_q.push_back(b);
            req_q.push_back(pos[31:2]);
            pos += 32'(un);
            rem -= un;
            fst = 0;
        end
    endtask

    task automatic cycle();
        beat_t ob;
        int due;
        rd_rsp_valid = rst_n && pend.size() > 0 && pend[0].due <= cyc && rsp_budget != 0;
        rd_rsp_data  = rd_rsp_valid ? mem_word(pend[0].addr) : 32'h0;
        rd_req_ready = $urandom_range(0, 99) < req_pct;
        dst_ready    = dst_mode == 1 || (dst_mode == 2 && $urandom_range(0, 99) < 70);
        #1;
        ob = obs_beat();
        if (prev_stall && rst_n) chk("hold", {dst_valid, ob}, {1'b1, prev_b});
        if (rst_n) begin
            if (rd_req_valid && rd_req_ready) begin
                req_cnt++;
                outstanding++;
                chk("credit_bound", outstanding <= MO, 1);
                if (req_q.size() == 0) fail_now("req_unexpected", rd_req_addr);
                else chk("req_addr", rd_req_addr, req_q.pop_front());
                due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                pend.push_back('{rd_req_addr, due});
                last_due = due;
            end
            if (dst_valid && dst_ready) begin
                beat_cnt++;
                outstanding--;
                if (dst_done) done_cnt++;
                if (dst_last) last_cnt++;
                if (exp_q.size() == 0) fail_now("beat_unexpected", ob);
                else chk("beat", ob, exp_q.pop_front());
                if (dst_bgin) begin
                    obs_n  = 0;
                    obs_fu = int'(dst_unit_num);
                    obs_fo = int'(dst_offset);
                end
                obs_n++;
                obs_lu = int'(dst_unit_num);
            end
            if (rd_rsp_valid) begin
                void'(pend.pop_front());
                if (rsp_budget > 0) rsp_budget--;
            end
            if (cmd_valid && cmd_ready && !flush) begin
                acc = 1;
                model_cmd(cmd_addr, int'(cmd_len), cmd_dst_offset, cmd_last, cmd_user_info);
            end
            if (flush) begin
                exp_q.delete();
                req_q.delete();
                outstanding = 0;
            end
        end
        prev_stall = rst_n && !flush && dst_valid && !dst_ready;
        prev_b = ob;
        @(negedge clk);
        cyc++;
    endtask

    task automatic send_cmd(logic [31:0] a, int len, logic [1:0] d, logic l, logic [7:0] u);
        cmd_addr = a;
        cmd_len = 16'(len);
        cmd_dst_offset = d;
        cmd_last = l;
        cmd_user_info = u;
        cmd_valid = 1;
        acc = 0;
        for (int k = 0; k < 500 && !acc; k++) cycle();
        cmd_valid = 0;
        chk("cmd_accept", acc, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && (exp_q.size() + req_q.size() + pend.size()) != 0; k++) cycle();
        chk("drain", exp_q.size() + req_q.size() + pend.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[10];
        int r0, b0;
        tv[0] = '{32'h6, 7, 3, 2, 2, 1};
        tv[1] = '{32'h1, 2, 1, 2, 1, 2};
        tv[2] = '{32'h0, 4, 1, 4, 0, 4};
        tv[3] = '{32'h10, 3, 1, 3, 0, 3};
        tv[4] = '{32'h3, 1, 1, 1, 3, 1};
        tv[5] = '{32'h2, 10, 3, 2, 2, 4};
        tv[6] = '{32'h5, 0, 0, 0, 0, 0};
        tv[7] = '{32'hFFFFFFFF, 2, 2, 1, 3, 1};
        tv[8] = '{32'h0, 40, 10, 4, 0, 4};
        tv[9] = '{32'h7, 5, 2, 1, 3, 4};

        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_req_valid", rd_req_valid, 0);
        chk("rst_dst_valid", dst_valid, 0);
        chk("rst_dst_fields", obs_beat(), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 10; i++) begin
            obs_n = 0; obs_fu = 0; obs_fo = 0; obs_lu = 0;
            lat = 1 + i % 3;
            r0 = req_cnt;
            send_cmd(tv[i].addr, tv[i].len, 2'(i), i[0], 8'(8'hA0 + i));
            drain();
            chk("vec_beats", obs_n, tv[i].beats);
            chk("vec_reqs", req_cnt - r0, tv[i].beats);
            chk("vec_first_units", obs_fu, tv[i].fu);
            chk("vec_first_off", obs_fo, tv[i].fo);
            chk("vec_last_units", obs_lu, tv[i].lu);
        end

        lat = 2;
        dst_mode = 0;
        r0 = req_cnt;
        obs_n = 0;
        send_cmd(32'h0, 40, 2'd1, 1'b1, 8'h3C);
        repeat (20) cycle();
        chk("bp_req_count", req_cnt - r0, 4);
        chk("bp_req_valid", rd_req_valid, 0);
        dst_mode = 1;
        drain();
        chk("bp_beats", obs_n, 10);

        b0 = done_cnt;
        r0 = last_cnt;
        send_cmd(32'h0, 4, 2'd0, 1'b0, 8'h11);
        send_cmd(32'h10, 3, 2'd3, 1'b1, 8'h22);
        drain();
        chk("b2b_done", done_cnt - b0, 2);
        chk("b2b_last", last_cnt - r0, 1);

        dst_mode = 0;
        rsp_budget = 1;
        r0 = req_cnt;
        send_cmd(32'h0, 40, 2'd2, 1'b1, 8'h77);
        repeat (10) cycle();
        chk("fl_buffered", dst_valid, 1);
        chk("fl_reqs", req_cnt - r0, 4);
        flush = 1;
        cycle();
        flush = 0;
        chk("fl_dst_valid", dst_valid, 0);
        chk("fl_req_valid", rd_req_valid, 0);
        chk("fl_cmd_ready", cmd_ready, 0);
        rsp_budget = -1;
        dst_mode = 1;
        b0 = beat_cnt;
        for (int k = 0; k < 50 && pend.size() != 0; k++) begin
            cycle();
            if (pend.size() != 0) chk("fl_discard_ready", cmd_ready, 0);
        end
        chk("fl_ready_after", cmd_ready, 1);
        chk("fl_no_beats", beat_cnt - b0, 0);
        send_cmd(32'h6, 7, 2'd1, 1'b1, 8'h5A);
        drain();

        for (int i = 0; i < 60; i++) begin
            int len;
            lat = $urandom_range(1, 4);
            req_pct = $urandom_range(40, 100);
            dst_mode = 2;
            len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24);
            send_cmd($urandom, len, 2'($urandom), 1'($urandom), 8'($urandom));
        end
        drain();
        req_pct = 100;
        dst_mode = 1;

        dst_mode = 0;
        lat = 2;
        send_cmd(32'h0, 40, 2'd0, 1'b1, 8'h99);
        repeat (3) cycle();
        rst_n = 0;
        #1;
        chk("ar_req_valid", rd_req_valid, 0);
        chk("ar_dst_valid", dst_valid, 0);
        chk("ar_cmd_ready", cmd_ready, 1);
        chk("ar_dst_fields", obs_beat(), 0);
        exp_q.delete();
        req_q.delete();
        pend.delete();
        outstanding = 0;
        prev_stall = 0;
        repeat (2) cycle();
        rst_n = 1;
        dst_mode = 1;
        r0 = req_cnt;
        b0 = beat_cnt;
        repeat (20) cycle();
        chk("ar_no_reqs", req_cnt - r0, 0);
        chk("ar_no_beats", beat_cnt - b0, 0);
        send_cmd(32'h1, 2, 2'd2, 1'b1, 8'hE1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
